// File: rtl/telemetry_pkg.sv
// Shared definitions for the telemetry value formatter.
//   ASCII_ZERO / ASCII_SPACE / ASCII_NINE : byte constants used when formatting digits
//   fmt_state_t                           : conversion FSM states
//   bcd_digits(width)                     : BCD digit count that holds any width-bit unsigned value
package telemetry_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_NINE  = 8'h39;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        STORE,
        COMMIT
    } fmt_state_t;

    // ceil(width * log10(2)) + 1, using log10(2) ~= 0.30103 in fixed point.
    // width * log10(2) is never an exact integer for width > 0, so rounding up is safe.
    function automatic int bcd_digits(input int width);
        return (width * 30103 + 99999) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble that is >= 5,
// then shift the whole vector left by one with bit_in entering the LSB.
//   bcd_in  : current BCD accumulator (DIGITS nibbles)
//   bit_in  : next binary bit, MSB first
//   bcd_out : corrected and shifted accumulator
module bcd_dabble_step #(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic                bit_in,
    output logic [4*DIGITS-1:0] bcd_out
);

    logic [4*DIGITS-1:0] adj;

    always_comb begin
        adj = bcd_in;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_in[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = bcd_in[4*d +: 4] + 4'd3;
            end
        end
        bcd_out = {adj[4*DIGITS-2:0], bit_in};
    end

endmodule

// File: rtl/telemetry_value_formatter.sv
// Converts NUM_SIGNALS unsigned telemetry values into fixed-width decimal ASCII
// for the text panel. All values are snapshotted on frame_start, converted one
// at a time with a serial double-dabble loop, and committed to digits_ascii in
// a single cycle so the panel never shows a mix of old and new values.
//   clk          : only clock
//   reset        : synchronous, active-high
//   frame_start  : one-cycle pulse that starts a conversion when idle
//   value        : live telemetry values (unsigned)
//   digits_ascii : committed ASCII digits, digit index 0 is most significant
//   busy         : high while a conversion is in progress
//   update_done  : one-cycle pulse in the first cycle new digits are visible
//   overrun      : high in any cycle where frame_start arrives while busy
module telemetry_value_formatter
    import telemetry_pkg::*;
#(
    parameter int NUM_SIGNALS         = 7,
    parameter int VALUE_WIDTH         = 9,
    parameter int NUM_VALUE_DIGITS    = 3,
    parameter int BLANK_LEADING_ZEROS = 0
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               frame_start,
    input  logic [NUM_SIGNALS-1:0][VALUE_WIDTH-1:0]            value,
    output logic [NUM_SIGNALS-1:0][NUM_VALUE_DIGITS-1:0][7:0]  digits_ascii,
    output logic                                               busy,
    output logic                                               update_done,
    output logic                                               overrun
);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam int              BCD_DIGITS = bcd_digits(VALUE_WIDTH);
    localparam int              BCD_W      = 4 * BCD_DIGITS;
    localparam int              IDX_W      = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1;
    localparam int              CNT_W      = (VALUE_WIDTH > 1) ? $clog2(VALUE_WIDTH) : 1;
    localparam longint unsigned SAT_LIMIT  = pow10(NUM_VALUE_DIGITS) - 1;

    // Saturate values that do not fit, otherwise emit the low digits as ASCII
    // and optionally blank leading zeros (the last digit always stays visible).
    function automatic logic [NUM_VALUE_DIGITS-1:0][7:0] format_row(
        input logic [VALUE_WIDTH-1:0] raw,
        input logic [BCD_W-1:0]       bcd_val
    );
        logic [NUM_VALUE_DIGITS-1:0][7:0] row;
        logic                             leading;
        if (64'(raw) > SAT_LIMIT) begin
            row = {NUM_VALUE_DIGITS{ASCII_NINE}};
        end else begin
            for (int k = 0; k < NUM_VALUE_DIGITS; k++) begin
                // Shifting past the top of bcd_val yields zero digits when the
                // field is wider than the BCD accumulator.
                row[k] = ASCII_ZERO + {4'b0000, 4'(bcd_val >> (4 * (NUM_VALUE_DIGITS - 1 - k)))};
            end
            if (BLANK_LEADING_ZEROS != 0) begin
                leading = 1'b1;
                for (int k = 0; k < NUM_VALUE_DIGITS - 1; k++) begin
                    if (leading && row[k] == ASCII_ZERO) begin
                        row[k] = ASCII_SPACE;
                    end else begin
                        leading = 1'b0;
                    end
                end
            end
        end
        return row;
    endfunction

    fmt_state_t                                        state;
    logic [IDX_W-1:0]                                  sig_idx;
    logic [CNT_W-1:0]                                  bit_cnt;
    logic [VALUE_WIDTH-1:0]                            bin_sr;
    logic [BCD_W-1:0]                                  bcd;
    logic [BCD_W-1:0]                                  bcd_next;
    logic [NUM_SIGNALS-1:0][VALUE_WIDTH-1:0]           snapshot;
    logic [NUM_SIGNALS-1:0][NUM_VALUE_DIGITS-1:0][7:0] staging;

    bcd_dabble_step #(
        .DIGITS (BCD_DIGITS)
    ) u_step (
        .bcd_in  (bcd),
        .bit_in  (bin_sr[VALUE_WIDTH-1]),
        .bcd_out (bcd_next)
    );

    // A request while busy is dropped; flag it in the same cycle it arrives.
    assign overrun = frame_start && busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sig_idx      <= '0;
            bit_cnt      <= '0;
            bin_sr       <= '0;
            bcd          <= '0;
            snapshot     <= '0;
            staging      <= '0;
            digits_ascii <= {(NUM_SIGNALS * NUM_VALUE_DIGITS){ASCII_ZERO}};
            busy         <= 1'b0;
            update_done  <= 1'b0;
        end else begin
            update_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        snapshot <= value;
                        sig_idx  <= '0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                // Begin conversion of one snapshot entry
                LOAD: begin
                    bin_sr  <= snapshot[sig_idx];
                    bcd     <= '0;
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end
                // One binary bit per cycle, MSB first
                SHIFT: begin
                    bcd    <= bcd_next;
                    bin_sr <= bin_sr << 1;
                    if (bit_cnt == CNT_W'(VALUE_WIDTH - 1)) begin
                        state <= STORE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                // Format the finished row into staging
                STORE: begin
                    staging[sig_idx] <= format_row(snapshot[sig_idx], bcd);
                    if (sig_idx == IDX_W'(NUM_SIGNALS - 1)) begin
                        state <= COMMIT;
                    end else begin
                        sig_idx <= sig_idx + IDX_W'(1);
                        state   <= LOAD;
                    end
                end
                // Publish every row at once
                COMMIT: begin
                    digits_ascii <= staging;
                    update_done  <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_telemetry_value_formatter.sv
// Directed bench for telemetry_value_formatter: default configuration, a
// two-digit saturating configuration and a four-row leading-zero-blanking
// configuration, all sharing clock and reset.
module tb_telemetry_value_formatter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic fs0, fs1, fs2;

    logic [6:0][8:0]      val0, val1;
    logic [3:0][8:0]      val2;
    logic [6:0][2:0][7:0] dig0;
    logic [6:0][1:0][7:0] dig1;
    logic [3:0][2:0][7:0] dig2;
    logic busy0, busy1, busy2;
    logic done0, done1, done2;
    logic ovr0, ovr1, ovr2;

    int total = 0;
    int bad   = 0;

    telemetry_value_formatter u0 (
        .clk (clk), .reset (reset), .frame_start (fs0), .value (val0),
        .digits_ascii (dig0), .busy (busy0), .update_done (done0), .overrun (ovr0)
    );

    telemetry_value_formatter #(
        .NUM_SIGNALS (7), .VALUE_WIDTH (9), .NUM_VALUE_DIGITS (2), .BLANK_LEADING_ZEROS (0)
    ) u1 (
        .clk (clk), .reset (reset), .frame_start (fs1), .value (val1),
        .digits_ascii (dig1), .busy (busy1), .update_done (done1), .overrun (ovr1)
    );

    telemetry_value_formatter #(
        .NUM_SIGNALS (4), .VALUE_WIDTH (9), .NUM_VALUE_DIGITS (3), .BLANK_LEADING_ZEROS (1)
    ) u2 (
        .clk (clk), .reset (reset), .frame_start (fs2), .value (val2),
        .digits_ascii (dig2), .busy (busy2), .update_done (done2), .overrun (ovr2)
    );

    int a_vals[7]  = '{0, 1, 9, 10, 99, 100, 511};
    int b_vals[7]  = '{100, 42, 99, 0, 511, 5, 10};
    int c_vals[4]  = '{0, 7, 45, 305};
    int v1_vals[7] = '{123, 456, 7, 89, 300, 255, 64};
    int v2_vals[7] = '{1, 2, 3, 4, 5, 6, 7};

    logic [23:0] a_exp[7]  = '{"000", "001", "009", "010", "099", "100", "511"};
    logic [15:0] b_exp[7]  = '{"99", "42", "99", "00", "99", "05", "10"};
    logic [23:0] c_exp[4]  = '{"  0", "  7", " 45", "305"};
    logic [23:0] v1_exp[7] = '{"123", "456", "007", "089", "300", "255", "064"};
    logic [23:0] v2_exp[7] = '{"001", "002", "003", "004", "005", "006", "007"};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Text literals put the first character in the top byte; the port puts
    // digit 0 (most significant) in the bottom byte.
    function automatic logic [23:0] r3(input logic [23:0] s);
        return {s[7:0], s[15:8], s[23:16]};
    endfunction

    function automatic logic [15:0] r2(input logic [15:0] s);
        return {s[7:0], s[15:8]};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        fs0 = 1'b0; fs1 = 1'b0; fs2 = 1'b0;
        val0 = '0; val1 = '0; val2 = '0;
        repeat (3) next_cycle();
        reset = 1'b0;

        // Idle after reset: nothing moves without frame_start
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            #1;
            chk("idle_busy", busy0, 1'b0);
            chk("idle_done", done0, 1'b0);
        end
        for (int r = 0; r < 7; r++) chk($sformatf("rst_row%0d", r), dig0[r], r3("000"));
        for (int r = 0; r < 4; r++) chk($sformatf("rst_c_row%0d", r), dig2[r], r3("000"));

        // Basic conversion on all three instances, cycle 0
        next_cycle();
        for (int i = 0; i < 7; i++) begin
            val0[i] = 9'(a_vals[i]);
            val1[i] = 9'(b_vals[i]);
        end
        for (int i = 0; i < 4; i++) val2[i] = 9'(c_vals[i]);
        fs0 = 1'b1; fs1 = 1'b1; fs2 = 1'b1;
        #1;
        chk("a_busy_c0", busy0, 1'b0);
        chk("a_ovr_c0", ovr0, 1'b0);
        for (int c = 1; c <= 80; c++) begin
            next_cycle();
            fs0 = 1'b0; fs1 = 1'b0; fs2 = 1'b0;
            #1;
            if (c <= 78) begin
                chk($sformatf("a_busy_c%0d", c), busy0, 1'b1);
                chk($sformatf("a_done_c%0d", c), done0, 1'b0);
            end
            if (c == 45) chk("c_done_c45", done2, 1'b0);
            if (c == 46) begin
                chk("c_done_c46", done2, 1'b1);
                chk("c_busy_c46", busy2, 1'b0);
                for (int r = 0; r < 4; r++) chk($sformatf("c_row%0d", r), dig2[r], r3(c_exp[r]));
            end
            if (c == 79) begin
                chk("a_done_c79", done0, 1'b1);
                chk("a_busy_c79", busy0, 1'b0);
                chk("b_done_c79", done1, 1'b1);
                for (int r = 0; r < 7; r++) chk($sformatf("a_row%0d", r), dig0[r], r3(a_exp[r]));
                for (int r = 0; r < 7; r++) chk($sformatf("b_row%0d", r), dig1[r], r2(b_exp[r]));
            end
            if (c == 80) chk("a_done_c80", done0, 1'b0);
        end

        // Overrun: second request ignored, values changed after snapshot
        next_cycle();
        for (int i = 0; i < 7; i++) val0[i] = 9'(v1_vals[i]);
        fs0 = 1'b1;
        #1;
        chk("o_ovr_c0", ovr0, 1'b0);
        for (int c = 1; c <= 200; c++) begin
            next_cycle();
            fs0 = (c == 30);
            if (c == 5) for (int i = 0; i < 7; i++) val0[i] = 9'(v2_vals[i]);
            #1;
            if (c == 29) chk("o_ovr_c29", ovr0, 1'b0);
            if (c == 30) chk("o_ovr_c30", ovr0, 1'b1);
            if (c == 31) chk("o_ovr_c31", ovr0, 1'b0);
            if (c == 79) begin
                chk("o_done_c79", done0, 1'b1);
                for (int r = 0; r < 7; r++) chk($sformatf("o_row%0d", r), dig0[r], r3(v1_exp[r]));
            end
            if (c > 79) chk($sformatf("o_nodone_c%0d", c), done0, 1'b0);
            if (c == 120) chk("o_busy_c120", busy0, 1'b0);
        end

        // Reset in the middle of a conversion, then a clean restart
        next_cycle();
        fs0 = 1'b1;
        #1;
        for (int c = 1; c <= 40; c++) begin
            next_cycle();
            fs0 = 1'b0;
            reset = (c == 40);
            #1;
        end
        next_cycle();
        reset = 1'b0;
        #1;
        chk("r_busy", busy0, 1'b0);
        chk("r_done", done0, 1'b0);
        for (int r = 0; r < 7; r++) chk($sformatf("r_row%0d", r), dig0[r], r3("000"));

        next_cycle();
        fs0 = 1'b1;
        #1;
        for (int c = 1; c <= 79; c++) begin
            next_cycle();
            fs0 = 1'b0;
            #1;
            if (c == 78) begin
                chk("r2_busy_c78", busy0, 1'b1);
                chk("r2_done_c78", done0, 1'b0);
            end
            if (c == 79) begin
                chk("r2_done_c79", done0, 1'b1);
                for (int r = 0; r < 7; r++) chk($sformatf("r2_row%0d", r), dig0[r], r3(v2_exp[r]));
                // Request in the update_done cycle is accepted, not an overrun
                fs0 = 1'b1;
                #1;
                chk("r2_ovr_c79", ovr0, 1'b0);
            end
        end
        next_cycle();
        fs0 = 1'b0;
        #1;
        chk("r2_accept_busy", busy0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/telemetry_value_formatter.md
Name: telemetry_value_formatter

Overview:
- Sequential stage directly upstream of the telemetry text panel; produces the per-signal decimal ASCII digits the panel places after "LABEL: ".
- Samples all NUM_SIGNALS values on a frame-start pulse and converts them one at a time with a shift-add-3 (double-dabble) loop.
- Commits all digits in a single cycle, so the panel never shows a frame with mixed old and new values.
- Removes the wide combinational divide/modulo path from the VGA pixel clock domain.

Parameters:
- NUM_SIGNALS, 7: number of telemetry values (rows).
- VALUE_WIDTH, 9: bit width of each unsigned value.
- NUM_VALUE_DIGITS, 3: decimal digits emitted per value.
- BLANK_LEADING_ZEROS, 0: 1 = replace leading '0' digits with ' '; the least-significant digit is never blanked.

Ports:
- clk  input  1  pixel/system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- frame_start  input  1  single-cycle pulse at the start of vertical blanking.
- value  input  [NUM_SIGNALS][VALUE_WIDTH]  live telemetry values, unsigned.
- digits_ascii  output  [NUM_SIGNALS][NUM_VALUE_DIGITS][8]  committed ASCII digits; index 0 is the most-significant digit.
- busy  output  1  high while a conversion is in progress.
- update_done  output  1  one-cycle pulse in the first cycle new digits are visible.
- overrun  output  1  one-cycle pulse when frame_start arrives while busy.

Behaviour:
- Reset (synchronous): FSM to IDLE; every digits_ascii byte = "0" (8'h30); busy = update_done = overrun = 0; snapshot, staging and BCD registers cleared. A reset during conversion discards all partial results.
- States: IDLE, LOAD, SHIFT, STORE, COMMIT.
- IDLE: when frame_start = 1, capture all value[] into the snapshot array on that edge, set sig_idx = 0, go to LOAD.
- LOAD (1 cycle): bin_sr <= snapshot[sig_idx]; bcd <= 0; bit_cnt <= 0.
- SHIFT (VALUE_WIDTH cycles): for each BCD nibble >= 5, add 3; then shift {bcd, bin_sr} left by 1. After bit_cnt reaches VALUE_WIDTH-1, go to STORE.
- BCD register width: ceil(VALUE_WIDTH*log10(2)) + 1 digits, enough for the full input range.
- STORE (1 cycle):
  - If snapshot[sig_idx] > 10^NUM_VALUE_DIGITS - 1, write all '9' (saturate).
  - Otherwise write the low NUM_VALUE_DIGITS nibbles as "0" + nibble.
  - Apply blanking if BLANK_LEADING_ZEROS = 1.
  - Write to staging[sig_idx].
  - If sig_idx = NUM_SIGNALS-1, go to COMMIT; else increment sig_idx and go to LOAD.
- COMMIT (1 cycle): digits_ascii <= staging (all rows together); return to IDLE.
- Timing: update_done = 1 in the cycle after COMMIT, which is the first cycle the new digits_ascii is visible.
- busy = 1 in every non-IDLE state.
- Latency: frame_start accepted in cycle 0, then new digits visible in cycle 2 + NUM_SIGNALS*(VALUE_WIDTH+2). With defaults that is cycle 79.
- frame_start while busy: ignored (no restart, no re-snapshot); overrun pulses for 1 cycle.
- frame_start in the same cycle as update_done: accepted normally, since the FSM is already in IDLE.
- value[] changes after the snapshot edge have no effect on the current conversion.
- digits_ascii holds its value between commits. It is purely registered, with no combinational path from value[].

Decomposition:
- telemetry_pkg holds:
  - ASCII_ZERO = 8'h30, ASCII_SPACE = 8'h20, ASCII_NINE = 8'h39.
  - fmt_state_t enum {IDLE, LOAD, SHIFT, STORE, COMMIT}.
  - function bcd_digits(width) returning the BCD register digit count.
- Sub-module bcd_dabble_step: combinational; takes a BCD vector plus an incoming bit and returns the add-3-corrected, shifted BCD vector. Used once inside SHIFT.

Test Plan:
- Reset, then no frame_start: digits_ascii all "000", busy = 0, update_done never pulses.
- value = {0, 1, 9, 10, 99, 100, 511}, frame_start in cycle 0: busy high cycles 1–78; update_done in cycle 79; rows read "000","001","009","010","099","100","511".
- Defaults with NUM_VALUE_DIGITS = 2, value[0] = 100: row 0 reads "99" (saturated); value[1] = 42 reads "42".
- BLANK_LEADING_ZEROS = 1, values {0, 7, 45, 305}: rows read "  0", "  7", " 45", "305".
- frame_start at cycle 0 and again at cycle 30, with value[] changed at cycle 5: overrun pulses at cycle 30; the commit at cycle 79 reflects the cycle-0 snapshot; no second commit follows.
- reset asserted at cycle 40 of a conversion: next cycle busy = 0 and digits_ascii all "0"; a later frame_start converts normally with full latency.
